token_fsm_param: RTL and testbench

- Parametrised successor to the per-tile token-exchange DVFS controller.
- Holds a signed token budget and exchanges status/update packets with NEIGH configurable neighbours over the NoC.
- Splits tokens proportionally to need, using a multi-cycle restoring divider.
- Maps tokens to an LDO frequency code through a programmable LUT, with a thermal cooldown mode that sheds tokens.

---
 rtl/token_fsm_param.sv | 247 ++++++++++++++++++++++++
 tb/tb_token_fsm_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/token_fsm_param.sv
// Per-tile DVFS token controller: exchanges token status/updates with NEIGH neighbours,
// rebalances tokens with a restoring divider and maps the budget to an LDO code via a LUT.
module token_fsm_param #(
  parameter int TOK_W    = 7,
  parameter int NEIGH    = 4,
  parameter int ADDR_W   = 5,
  parameter int LUT_AW   = 6,
  parameter int FREQ_W   = 8,
  parameter int RATE_W   = 12,
  parameter int COOL_CYC = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     activity,
  input  logic [TOK_W-2:0]         max_tokens,
  input  logic                     pkt_in_valid,
  output logic                     pkt_in_ready,
  input  logic [31:0]              pkt_in_data,
  input  logic [ADDR_W-1:0]        pkt_in_src,
  output logic                     pkt_out_valid,
  input  logic                     pkt_out_ready,
  output logic [31:0]              pkt_out_data,
  output logic [ADDR_W-1:0]        pkt_out_addr,
  input  logic [NEIGH*ADDR_W-1:0]  neighbors_id,
  input  logic [RATE_W-1:0]        refresh_rate,
  input  logic                     lut_wr_en,
  input  logic [LUT_AW-1:0]        lut_addr,
  input  logic [FREQ_W-1:0]        lut_wdata,
  output logic [FREQ_W-1:0]        lut_rdata,
  input  logic                     thermal_overrun,
  input  logic                     tok_ovr_en,
  input  logic signed [TOK_W-1:0]  tok_ovr_val,
  output logic signed [TOK_W-1:0]  tokens,
  output logic [FREQ_W-1:0]        freq_target,
  output logic                     cooling
);

  localparam int NUM_W  = 2*TOK_W + 1;
  localparam int DVD_W  = 2*TOK_W;
  localparam int CNT_W  = $clog2(DVD_W);
  localparam int LUT_D  = 1 << LUT_AW;
  localparam int SIDE_W = (NEIGH > 1) ? $clog2(NEIGH) : 1;
  localparam int COOL_W = $clog2(COOL_CYC + 1);
  localparam logic signed [TOK_W-1:0] T_MAX = {1'b0, {(TOK_W-1){1'b1}}};
  localparam logic signed [TOK_W-1:0] T_MIN = {1'b1, {(TOK_W-1){1'b0}}};
  localparam logic [DVD_W-1:0] MAG_POS = DVD_W'(2**(TOK_W-1) - 1);
  localparam logic [DVD_W-1:0] MAG_NEG = DVD_W'(2**(TOK_W-1));

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_STAT = 3'd1;
  localparam logic [2:0] S_DIV       = 3'd2;
  localparam logic [2:0] S_SEND_UPD  = 3'd3;
  localparam logic [2:0] S_COOL      = 3'd4;

  logic [2:0]               state;
  logic [RATE_W-1:0]        ref_cnt;
  logic [SIDE_W-1:0]        side;
  logic [COOL_W-1:0]        cool_cnt;
  logic [FREQ_W-1:0]        lut [LUT_D];
  logic [ADDR_W-1:0]        src_r;
  logic [DVD_W-1:0]         quo;
  logic [TOK_W-1:0]         rem;
  logic [TOK_W-1:0]         den_r;
  logic [CNT_W-1:0]         div_cnt;
  logic                     num_neg, den_zero;
  logic signed [TOK_W-1:0]  delta_r;

  function automatic logic signed [TOK_W-1:0] sat_add(input logic signed [TOK_W-1:0] a,
                                                      input logic signed [TOK_W-1:0] b);
    logic [TOK_W:0] s;
    s = {a[TOK_W-1], a} + {b[TOK_W-1], b};
    if (s[TOK_W] != s[TOK_W-1]) return s[TOK_W] ? T_MIN : T_MAX;
    return s[TOK_W-1:0];
  endfunction

  logic [TOK_W-2:0]         need, in_nr;
  logic signed [TOK_W-1:0]  in_delta, tok_nx, div_delta, fin_delta, neg_delta, zero_delta;
  logic                     in_acc, in_stat, out_hs, upd_ok, shed, fits;
  logic signed [NUM_W-1:0]  hr_x, hs_x, ns_x, nr_x, num_c, mag_full;
  logic [TOK_W-1:0]         den_c;
  logic [TOK_W:0]           diff0, trial, diff;
  logic [TOK_W-1:0]         rem_nx;
  logic [DVD_W-1:0]         quo_nx;
  logic [31:0]              stat_data, upd_data;
  int                       tok_i;
  logic [LUT_AW-1:0]        lut_idx;

  assign pkt_in_ready = !reset && (state == S_IDLE || state == S_COOL);
  assign cooling      = (state == S_COOL);

  // NOTE: every always_comb output is defaulted first so no path can leave a latch.
  always_comb begin
    need     = activity ? max_tokens : '0;
    in_acc   = pkt_in_valid && pkt_in_ready;
    in_stat  = pkt_in_data[31];
    in_delta = pkt_in_data[TOK_W-1:0];
    in_nr    = pkt_in_data[10+TOK_W-2:10];
    out_hs   = pkt_out_valid && pkt_out_ready;

    // Exchange operands sampled on the cycle the status packet is accepted
    hr_x     = {{(NUM_W-TOK_W){in_delta[TOK_W-1]}}, in_delta};
    hs_x     = {{(NUM_W-TOK_W){tokens[TOK_W-1]}}, tokens};
    ns_x     = {{(NUM_W-TOK_W+1){1'b0}}, need};
    nr_x     = {{(NUM_W-TOK_W+1){1'b0}}, in_nr};
    num_c    = hr_x * ns_x - hs_x * nr_x;
    mag_full = num_c[NUM_W-1] ? -num_c : num_c;
    den_c    = {1'b0, need} + {1'b0, in_nr};
    diff0    = {in_delta[TOK_W-1], in_delta} - {tokens[TOK_W-1], tokens};
    zero_delta = diff0[TOK_W:1];

    trial  = {rem, quo[DVD_W-1]};
    diff   = trial - {1'b0, den_r};
    fits   = (trial >= {1'b0, den_r});
    rem_nx = fits ? diff[TOK_W-1:0] : trial[TOK_W-1:0];
    quo_nx = {quo[DVD_W-2:0], fits};
    if (num_neg) div_delta = (quo_nx > MAG_NEG) ? T_MIN : -quo_nx[TOK_W-1:0];
    else         div_delta = (quo_nx > MAG_POS) ? T_MAX : quo_nx[TOK_W-1:0];
    fin_delta = den_zero ? delta_r : div_delta;
    neg_delta = (fin_delta == T_MIN) ? T_MAX : -fin_delta;

    stat_data = '0;
    stat_data[31] = 1'b1;
    stat_data[10+TOK_W-2:10] = need;
    stat_data[TOK_W-1:0] = tokens;
    upd_data = '0;
    upd_data[TOK_W-1:0] = neg_delta;

    upd_ok = in_acc && !in_stat && (state == S_COOL || enable);
    shed   = thermal_overrun && (state == S_COOL || (state == S_IDLE && enable));
    tok_nx = tokens;
    if (state == S_SEND_UPD && out_hs) tok_nx = sat_add(tokens, delta_r);
    if (upd_ok) tok_nx = sat_add(tokens, in_delta);
    if (shed && !tok_nx[TOK_W-1] && tok_nx != '0) tok_nx = tok_nx - TOK_W'(1);
    if (tok_ovr_en) tok_nx = tok_ovr_val;

    tok_i = int'(tokens);
    if (tok_i < 0)           lut_idx = '0;
    else if (tok_i >= LUT_D) lut_idx = '1;
    else                     lut_idx = tok_i[LUT_AW-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{pkt_in_data[30:10+TOK_W-1], pkt_in_data[9:TOK_W], diff[TOK_W],
                         mag_full[NUM_W-1:DVD_W]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      tokens        <= '0;
      ref_cnt       <= '0;
      side          <= '0;
      cool_cnt      <= '0;
      src_r         <= '0;
      quo           <= '0;
      rem           <= '0;
      den_r         <= '0;
      div_cnt       <= '0;
      num_neg       <= 1'b0;
      den_zero      <= 1'b0;
      delta_r       <= '0;
      pkt_out_valid <= 1'b0;
      pkt_out_data  <= '0;
      pkt_out_addr  <= '0;
      freq_target   <= '0;
      lut_rdata     <= '0;
      // NOTE: the LUT must read back as zero after reset, so it is cleared here; this
      // keeps it in flops rather than a RAM macro, which is acceptable at this depth.
      for (int i = 0; i < LUT_D; i++) lut[i] <= '0;
    end else begin
      tokens      <= tok_nx;
      freq_target <= (state == S_COOL) ? lut[0] : lut[lut_idx];
      lut_rdata   <= lut[lut_addr];
      if (lut_wr_en) lut[lut_addr] <= lut_wdata;

      case (state)
        S_IDLE: begin
          ref_cnt <= ref_cnt + RATE_W'(1);
          if (!enable) begin
            ref_cnt <= '0;
          end else if (thermal_overrun) begin
            state    <= S_COOL;
            cool_cnt <= COOL_W'(COOL_CYC);
          end else if (in_acc && in_stat) begin
            state    <= S_DIV;
            src_r    <= pkt_in_src;
            den_r    <= den_c;
            den_zero <= (den_c == '0);
            num_neg  <= num_c[NUM_W-1];
            quo      <= mag_full[DVD_W-1:0];
            rem      <= '0;
            div_cnt  <= CNT_W'(DVD_W - 1);
            delta_r  <= zero_delta;
          end else if (ref_cnt >= refresh_rate) begin
            state         <= S_SEND_STAT;
            ref_cnt       <= '0;
            pkt_out_valid <= 1'b1;
            pkt_out_addr  <= neighbors_id[int'(side)*ADDR_W +: ADDR_W];
            pkt_out_data  <= stat_data;
          end
        end
        S_SEND_STAT: begin
          if (!enable) begin
            state         <= S_IDLE;
            ref_cnt       <= '0;
            pkt_out_valid <= 1'b0;
          end else if (pkt_out_ready) begin
            state         <= S_IDLE;
            pkt_out_valid <= 1'b0;
            side          <= (side == SIDE_W'(NEIGH - 1)) ? '0 : side + SIDE_W'(1);
          end
        end
        S_DIV: begin
          if (den_zero || div_cnt == '0) begin
            state         <= S_SEND_UPD;
            delta_r       <= fin_delta;
            pkt_out_valid <= 1'b1;
            pkt_out_addr  <= src_r;
            pkt_out_data  <= upd_data;
          end else begin
            rem     <= rem_nx;
            quo     <= quo_nx;
            div_cnt <= div_cnt - CNT_W'(1);
          end
        end
        S_SEND_UPD: begin
          if (pkt_out_ready) begin
            state         <= S_IDLE;
            pkt_out_valid <= 1'b0;
          end
        end
        S_COOL: begin
          if (thermal_overrun) begin
            cool_cnt <= COOL_W'(COOL_CYC);
          end else if (cool_cnt <= COOL_W'(1)) begin
            state    <= S_IDLE;
            cool_cnt <= '0;
          end else begin
            cool_cnt <= cool_cnt - COOL_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_fsm_param.sv
// Directed bench for token_fsm_param: expected packets go into a scoreboard queue and a
// negedge monitor pops and compares them on every output handshake.
module tb_token_fsm_param;

  localparam int TOK_W = 7, NEIGH = 4, ADDR_W = 5, LUT_AW = 6, FREQ_W = 8, RATE_W = 12;
  localparam int COOL_CYC = 8;

  logic clock = 1'b0, reset;
  logic enable, activity, pkt_in_valid, pkt_in_ready, pkt_out_valid, pkt_out_ready;
  logic [TOK_W-2:0] max_tokens;
  logic [31:0] pkt_in_data, pkt_out_data;
  logic [ADDR_W-1:0] pkt_in_src, pkt_out_addr;
  logic [NEIGH*ADDR_W-1:0] neighbors_id;
  logic [RATE_W-1:0] refresh_rate;
  logic lut_wr_en, thermal_overrun, tok_ovr_en, cooling;
  logic [LUT_AW-1:0] lut_addr;
  logic [FREQ_W-1:0] lut_wdata, lut_rdata, freq_target;
  logic signed [TOK_W-1:0] tok_ovr_val, tokens;

  token_fsm_param #(.TOK_W(TOK_W), .NEIGH(NEIGH), .ADDR_W(ADDR_W), .LUT_AW(LUT_AW),
                    .FREQ_W(FREQ_W), .RATE_W(RATE_W), .COOL_CYC(COOL_CYC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .activity(activity),
    .max_tokens(max_tokens), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .pkt_in_data(pkt_in_data), .pkt_in_src(pkt_in_src), .pkt_out_valid(pkt_out_valid),
    .pkt_out_ready(pkt_out_ready), .pkt_out_data(pkt_out_data), .pkt_out_addr(pkt_out_addr),
    .neighbors_id(neighbors_id), .refresh_rate(refresh_rate), .lut_wr_en(lut_wr_en),
    .lut_addr(lut_addr), .lut_wdata(lut_wdata), .lut_rdata(lut_rdata),
    .thermal_overrun(thermal_overrun), .tok_ovr_en(tok_ovr_en), .tok_ovr_val(tok_ovr_val),
    .tokens(tokens), .freq_target(freq_target), .cooling(cooling)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } pkt_t;

  pkt_t sb[$];
  pkt_t exp_pkt;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && pkt_out_valid && pkt_out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pkt: got addr %0d data 0x%0h, expected no packet",
                 pkt_out_addr, pkt_out_data);
      end else begin
        exp_pkt = sb.pop_front();
        check("pkt_addr", 32'(pkt_out_addr), 32'(exp_pkt.addr));
        check("pkt_data", pkt_out_data, exp_pkt.data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_pkt(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    sb.push_back('{addr: a, data: d});
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d packets still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_pkt(input logic [31:0] d, input logic [ADDR_W-1:0] s);
    pkt_in_valid = 1'b1;
    pkt_in_data  = d;
    pkt_in_src   = s;
    check("pkt_in_ready", 32'(pkt_in_ready), 32'd1);
    step(1);
    pkt_in_valid = 1'b0;
  endtask

  task automatic override(input int v);
    tok_ovr_en  = 1'b1;
    tok_ovr_val = TOK_W'(v);
    step(1);
    tok_ovr_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; activity = 1'b0; max_tokens = '0;
    pkt_in_valid = 1'b0; pkt_in_data = '0; pkt_in_src = '0; pkt_out_ready = 1'b0;
    neighbors_id = {5'd12, 5'd11, 5'd10, 5'd9}; refresh_rate = 12'd4095;
    lut_wr_en = 1'b0; lut_addr = '0; lut_wdata = '0; thermal_overrun = 1'b0;
    tok_ovr_en = 1'b0; tok_ovr_val = '0;
    #3;
    check("rst_tokens", tokens, 0);
    check("rst_freq", 32'(freq_target), 0);
    check("rst_out_valid", 32'(pkt_out_valid), 0);
    check("rst_cooling", 32'(cooling), 0);
    check("rst_in_ready", 32'(pkt_in_ready), 0);
    step(2);
    reset = 1'b0;
    step(1);

    // LUT programming and registered read-back
    lut_wr_en = 1'b1; lut_addr = 6'd0; lut_wdata = 8'h3C; step(1);
    lut_addr = 6'd63; lut_wdata = 8'hA5; step(1);
    lut_wr_en = 1'b0; step(1);
    check("lut_rd_63", 32'(lut_rdata), 32'hA5);
    lut_addr = 6'd0; step(1);
    check("lut_rd_0", 32'(lut_rdata), 32'h3C);

    // Refresh: statuses round-robin over slots 0,1,2,3,0 with has=5, need=20
    override(5);
    activity = 1'b1; max_tokens = 6'd20; pkt_out_ready = 1'b1; refresh_rate = 12'd15;
    expect_pkt(5'd9,  32'h8000_5005);
    expect_pkt(5'd10, 32'h8000_5005);
    expect_pkt(5'd11, 32'h8000_5005);
    expect_pkt(5'd12, 32'h8000_5005);
    expect_pkt(5'd9,  32'h8000_5005);
    enable = 1'b1;
    wait_sb_empty("refresh_statuses", 200);
    enable = 1'b0;
    step(2);

    // Exchange: Hs=10 Ns=30 Hr=20 Nr=10 -> 500/40 = 12, update carries -12
    refresh_rate = 12'd4095; pkt_out_ready = 1'b0; enable = 1'b1;
    override(10);
    max_tokens = 6'd30;
    expect_pkt(5'd7, 32'h0000_0074);
    send_pkt(32'h8000_2814, 5'd7);
    n = 0;
    while (!pkt_out_valid && n < 100) begin step(1); n++; end
    check("div_cycles", n, 14);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(pkt_out_valid), 1);
      check("stall_addr", 32'(pkt_out_addr), 7);
      check("stall_data", pkt_out_data, 32'h74);
      step(1);
    end
    pkt_out_ready = 1'b1;
    wait_sb_empty("exchange_update", 10);
    check("exch_tokens", tokens, 22);
    check("exch_valid_drop", 32'(pkt_out_valid), 0);

    // Zero denominator: (2-6)>>>1 = -2, update carries +2
    activity = 1'b0;
    override(6);
    expect_pkt(5'd3, 32'h0000_0002);
    send_pkt(32'h8000_0002, 5'd3);
    wait_sb_empty("zero_den_update", 20);
    check("zden_tokens", tokens, 4);

    // Thermal: three shed cycles, then COOL_CYC cycles of hold
    override(5);
    thermal_overrun = 1'b1;
    step(3);
    thermal_overrun = 1'b0;
    check("cool_tokens", tokens, 2);
    check("cool_flag", 32'(cooling), 1);
    check("cool_freq", 32'(freq_target), 32'h3C);
    n = 0;
    while (cooling && n < 50) begin step(1); n++; end
    check("cool_hold", n, 8);
    check("cool_tokens_kept", tokens, 2);

    // Saturation, LUT mapping, override priority
    override(63);
    send_pkt(32'd10, 5'd1);
    check("sat_pos", tokens, 63);
    step(1);
    check("freq_lut63", 32'(freq_target), 32'hA5);
    override(-60);
    send_pkt(32'h76, 5'd1);
    check("sat_neg", tokens, -64);
    tok_ovr_en = 1'b1; tok_ovr_val = TOK_W'(7);
    pkt_in_valid = 1'b1; pkt_in_data = 32'd3;
    step(1);
    tok_ovr_en = 1'b0; pkt_in_valid = 1'b0;
    check("ovr_wins", tokens, 7);
    override(-4);
    check("ovr_neg", tokens, -4);
    step(1);
    check("freq_neg", 32'(freq_target), 32'h3C);

    // Reset in the middle of a divide
    activity = 1'b1; max_tokens = 6'd30; pkt_out_ready = 1'b0;
    override(10);
    send_pkt(32'h8000_2814, 5'd7);
    step(5);
    reset = 1'b1;
    #1;
    check("mid_rst_tokens", tokens, 0);
    check("mid_rst_valid", 32'(pkt_out_valid), 0);
    check("mid_rst_data", pkt_out_data, 0);
    check("mid_rst_freq", 32'(freq_target), 0);
    check("mid_rst_lut_rd", 32'(lut_rdata), 0);
    check("mid_rst_in_ready", 32'(pkt_in_ready), 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
